// File: rtl/cpu_mem_access_unit_pkg.sv
// Shared types for the MEM-stage data-access slice.
// Memory op encoding, access FSM states and NZP codes.
package lc3b_types;

  typedef enum logic [1:0] {
    LOAD_W  = 2'd0,
    LOAD_B  = 2'd1,
    STORE_W = 2'd2,
    STORE_B = 2'd3
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } mau_state_t;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  function automatic logic op_is_store(input mem_op_t op);
    return op == STORE_W || op == STORE_B;
  endfunction

  function automatic logic op_is_byte(input mem_op_t op);
    return op == LOAD_B || op == STORE_B;
  endfunction

endpackage

// File: rtl/cpu_mem_access_unit_sb.sv
// In-order store buffer with youngest-match lookup.
// Entries hold word address, lane-placed data and byte enables.
module cpu_store_buffer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int SB_DEPTH = 4,
  localparam int BE_W    = DATA_W / 8,
  localparam int WA_W    = ADDR_W - $clog2(BE_W),
  localparam int PTR_W   = $clog2(SB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WA_W-1:0]   push_waddr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [BE_W-1:0]   push_be,
  input  logic              pop,
  output logic [WA_W-1:0]   head_waddr,
  output logic [DATA_W-1:0] head_data,
  output logic [BE_W-1:0]   head_be,
  output logic              full,
  output logic              empty,
  input  logic [WA_W-1:0]   look_waddr,
  input  logic [BE_W-1:0]   look_be,
  output logic              hit,
  output logic              full_cover,
  output logic [DATA_W-1:0] hit_data
);

  logic [WA_W-1:0]   waddr_q [SB_DEPTH];
  logic [DATA_W-1:0] data_q  [SB_DEPTH];
  logic [BE_W-1:0]   be_q    [SB_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic [BE_W-1:0]   hit_be;

  assign full       = count == (PTR_W+1)'(SB_DEPTH);
  assign empty      = count == '0;
  assign head_waddr = waddr_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];
  assign head_be    = be_q[rd_ptr];
  assign full_cover = hit && ((hit_be & look_be) == look_be);

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + (PTR_W+1)'(1);
      else if (pop && !push)
        count <= count - (PTR_W+1)'(1);
    end
  end

  // entry storage; a push into the slot being popped is safe
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[wr_ptr] <= push_waddr;
      data_q[wr_ptr]  <= push_data;
      be_q[wr_ptr]    <= push_be;
    end
  end

  // scan oldest to youngest so the last match wins
  always_comb begin
    hit      = 1'b0;
    hit_be   = '0;
    hit_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((PTR_W+1)'(i) < count &&
          waddr_q[rd_ptr + PTR_W'(i)] == look_waddr) begin
        hit      = 1'b1;
        hit_be   = be_q[rd_ptr + PTR_W'(i)];
        hit_data = data_q[rd_ptr + PTR_W'(i)];
      end
    end
  end

endmodule

// File: rtl/cpu_mem_access_unit.sv
// MEM-stage access engine: store buffer, load forwarding,
// DCache read/drain FSM, byte formatting and NZP generation.
module cpu_mem_access_unit
  import lc3b_types::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int SB_DEPTH  = 4,
  parameter bit SEXT_BYTE = 1'b0,
  localparam int BE_W      = DATA_W / 8,
  localparam int LANE_BITS = $clog2(BE_W),
  localparam int WA_W      = ADDR_W - LANE_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  mem_op_t           req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [2:0]        resp_cc,
  input  logic              drain_all,
  output logic              sb_empty,
  output logic [ADDR_W-1:0] d_address,
  output logic [DATA_W-1:0] d_wdata,
  output logic              d_read,
  output logic              d_write,
  output logic [BE_W-1:0]   d_byte_enable,
  input  logic [DATA_W-1:0] d_rdata,
  input  logic              d_mem_resp
);

  mau_state_t state, next;

  logic [LANE_BITS-1:0] lane, ld_lane;
  logic                 ld_byte;
  logic [WA_W-1:0]      waddr, head_waddr;
  logic [BE_W-1:0]      op_be, head_be;
  logic [DATA_W-1:0]    push_data, head_data, hit_data;
  logic [DATA_W-1:0]    ld_fmt, fwd_fmt;
  logic is_store, is_byte, full, buf_empty, hit, full_cover;
  logic pop, push, load_ok, fwd_go, miss_go;

  function automatic logic [DATA_W-1:0] fmt(
    input logic [DATA_W-1:0]    w,
    input logic [LANE_BITS-1:0] l,
    input logic                 b
  );
    logic [7:0] byt;
    byt = w[{l, 3'b000} +: 8];
    if (!b) return w;
    if (SEXT_BYTE) return {{(DATA_W-8){byt[7]}}, byt};
    return {{(DATA_W-8){1'b0}}, byt};
  endfunction

  function automatic logic [2:0] nzp(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1]) return CC_N;
    if (v == '0) return CC_Z;
    return CC_P;
  endfunction

  assign is_store  = op_is_store(req_op);
  assign is_byte   = op_is_byte(req_op);
  assign lane      = req_addr[LANE_BITS-1:0];
  assign waddr     = req_addr[ADDR_W-1:LANE_BITS];
  assign op_be     = is_byte ? BE_W'(1) << lane : '1;
  assign push_data = req_op == STORE_B ?
                     {BE_W{req_wdata[7:0]}} : req_wdata;

  assign pop     = state == DRAIN && d_mem_resp;
  assign load_ok = hit ? (full_cover && state != LOAD)
                       : state == IDLE;
  assign req_ready = req_valid && !drain_all &&
                     (is_store ? (!full || pop) : load_ok);
  assign push    = req_ready && is_store;
  assign fwd_go  = req_ready && !is_store && hit;
  assign miss_go = req_ready && !is_store && !hit;

  assign sb_empty = buf_empty && state == IDLE;
  assign ld_fmt   = fmt(d_rdata, ld_lane, ld_byte);
  assign fwd_fmt  = fmt(hit_data, lane, is_byte);

  cpu_store_buffer #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_waddr (waddr),
    .push_data  (push_data),
    .push_be    (op_be),
    .pop        (pop),
    .head_waddr (head_waddr),
    .head_data  (head_data),
    .head_be    (head_be),
    .full       (full),
    .empty      (buf_empty),
    .look_waddr (waddr),
    .look_be    (op_be),
    .hit        (hit),
    .full_cover (full_cover),
    .hit_data   (hit_data)
  );

  // next state: a missing load wins over draining in IDLE
  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (miss_go)         next = LOAD;
        else if (!buf_empty) next = DRAIN;
      end
      LOAD:    if (d_mem_resp) next = IDLE;
      DRAIN:   if (d_mem_resp) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // state plus registered DCache strobes and load results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      d_read        <= 1'b0;
      d_write       <= 1'b0;
      d_address     <= '0;
      d_wdata       <= '0;
      d_byte_enable <= '0;
      ld_lane       <= '0;
      ld_byte       <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_cc       <= 3'b000;
    end else begin
      state      <= next;
      resp_valid <= 1'b0;
      if (state == IDLE && next == LOAD) begin
        d_read        <= 1'b1;
        d_address     <= {waddr, {LANE_BITS{1'b0}}};
        d_byte_enable <= op_be;
        ld_lane       <= lane;
        ld_byte       <= is_byte;
      end
      if (state == IDLE && next == DRAIN) begin
        d_write       <= 1'b1;
        d_address     <= {head_waddr, {LANE_BITS{1'b0}}};
        d_wdata       <= head_data;
        d_byte_enable <= head_be;
      end
      if (state != IDLE && d_mem_resp) begin
        d_read  <= 1'b0;
        d_write <= 1'b0;
      end
      if (state == LOAD && d_mem_resp) begin
        resp_valid <= 1'b1;
        resp_rdata <= ld_fmt;
        resp_cc    <= nzp(ld_fmt);
      end
      if (fwd_go) begin
        resp_valid <= 1'b1;
        resp_rdata <= fwd_fmt;
        resp_cc    <= nzp(fwd_fmt);
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_access_unit.sv
// Bench for cpu_mem_access_unit: two instances differing
// only in byte sign-extension, a DCache responder and a scoreboard.
module tb_cpu_mem_access_unit;
  import lc3b_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, drain_all, d_mem_resp;
  mem_op_t     req_op;
  logic [15:0] req_addr, req_wdata, d_rdata;

  logic        req_ready0, resp_valid0, sb_empty0, d_read0, d_write0;
  logic [15:0] resp_rdata0, d_address0, d_wdata0;
  logic [2:0]  resp_cc0;
  logic [1:0]  d_byte_enable0;
  logic        req_ready1, resp_valid1, sb_empty1, d_read1, d_write1;
  logic [15:0] resp_rdata1, d_address1, d_wdata1;
  logic [2:0]  resp_cc1;
  logic [1:0]  d_byte_enable1;

  cpu_mem_access_unit #(.SEXT_BYTE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_ready(req_ready0), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid0),
    .resp_rdata(resp_rdata0), .resp_cc(resp_cc0),
    .drain_all(drain_all), .sb_empty(sb_empty0),
    .d_address(d_address0), .d_wdata(d_wdata0), .d_read(d_read0),
    .d_write(d_write0), .d_byte_enable(d_byte_enable0),
    .d_rdata(d_rdata), .d_mem_resp(d_mem_resp)
  );

  cpu_mem_access_unit #(.SEXT_BYTE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_ready(req_ready1), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid1),
    .resp_rdata(resp_rdata1), .resp_cc(resp_cc1),
    .drain_all(drain_all), .sb_empty(sb_empty1),
    .d_address(d_address1), .d_wdata(d_wdata1), .d_read(d_read1),
    .d_write(d_write1), .d_byte_enable(d_byte_enable1),
    .d_rdata(d_rdata), .d_mem_resp(d_mem_resp)
  );

  typedef struct {
    mem_op_t op; logic [15:0] addr; logic [15:0] wdata; bit fwd;
    logic [15:0] e0; logic [2:0] c0; logic [15:0] e1; logic [2:0] c1;
  } vec_t;

  typedef struct {
    logic [15:0] e0; logic [2:0] c0; logic [15:0] e1; logic [2:0] c1;
    bit fwd; int snap;
  } exp_t;

  typedef struct { logic [15:0] a; logic [15:0] d; logic [1:0] be; } wr_t;

  exp_t        sb_q[$];
  wr_t         wlog[$];
  vec_t        tbl[16];
  logic [15:0] cmem[256];
  int compared = 0;
  int mismatched = 0;
  int lat = 1;
  int rd_starts = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input vec_t v, output int waited,
                       output logic resp_at);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op;
    req_addr = v.addr; req_wdata = v.wdata;
    waited = 0;
    #1;
    while (!req_ready0 && waited < 300) begin
      @(negedge clk); #1; waited++;
    end
    resp_at = d_mem_resp;
    if (!req_ready0) begin
      chk("accept_timeout", {31'b0, req_ready0}, 1);
      req_valid = 1'b0;
      return;
    end
    if (v.op == LOAD_W || v.op == LOAD_B) begin
      e.e0 = v.e0; e.c0 = v.c0; e.e1 = v.e1; e.c1 = v.c1;
      e.fwd = v.fwd; e.snap = rd_starts;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while (!sb_empty0 && n < 500) begin @(negedge clk); n++; end
    chk(nm, {31'b0, sb_empty0}, 1);
  endtask

  // DCache responder: fixed latency, one-cycle completion pulse
  initial begin
    int cnt;
    logic [15:0] m;
    logic [7:0] idx;
    d_mem_resp = 1'b0; d_rdata = '0; cnt = 0;
    for (int i = 0; i < 256; i++) cmem[i] = '0;
    cmem[8'h80] = 16'h80AA;
    forever begin
      @(negedge clk);
      if (d_mem_resp) d_mem_resp = 1'b0;
      else if (d_read0 || d_write0) begin
        if (cnt < lat) cnt++;
        else begin
          cnt = 0; d_mem_resp = 1'b1;
          idx = d_address0[8:1];
          if (d_read0) d_rdata = cmem[idx];
          else begin
            m = cmem[idx];
            if (d_byte_enable0[0]) m[7:0] = d_wdata0[7:0];
            if (d_byte_enable0[1]) m[15:8] = d_wdata0[15:8];
            cmem[idx] = m;
            wlog.push_back('{d_address0, d_wdata0, d_byte_enable0});
          end
        end
      end else cnt = 0;
    end
  end

  // response monitor and read/write exclusivity
  initial begin
    exp_t e;
    logic prev_rd;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (d_read0 && !prev_rd) rd_starts++;
        prev_rd = d_read0;
        if (d_read0 || d_write0)
          chk("rw_exclusive", {31'b0, d_read0 & d_write0}, 0);
        if (resp_valid0 || resp_valid1) begin
          if (sb_q.size() == 0)
            chk("resp_unexpected", sb_q.size(), 1);
          else begin
            e = sb_q.pop_front();
            chk("rdata_zext", resp_rdata0, e.e0);
            chk("cc_zext", resp_cc0, e.c0);
            chk("rvalid_sext", resp_valid1, 1);
            chk("rdata_sext", resp_rdata1, e.e1);
            chk("cc_sext", resp_cc1, e.c1);
            if (e.fwd) chk("fwd_no_dread", rd_starts, e.snap);
            else chk("miss_dread", rd_starts > e.snap, 1);
          end
        end
      end else prev_rd = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    logic ra;
    vec_t v;
    tbl[0]  = '{STORE_W, 16'h0040, 16'hBEEF, 0, 0, 0, 0, 0};
    tbl[1]  = '{LOAD_W, 16'h0040, 0, 1, 16'hBEEF, 3'b100, 16'hBEEF, 3'b100};
    tbl[2]  = '{STORE_B, 16'h0041, 16'h007F, 0, 0, 0, 0, 0};
    tbl[3]  = '{LOAD_W, 16'h0040, 0, 0, 16'h7FEF, 3'b001, 16'h7FEF, 3'b001};
    tbl[4]  = '{LOAD_B, 16'h0101, 0, 0, 16'h0080, 3'b001, 16'hFF80, 3'b100};
    tbl[5]  = '{LOAD_B, 16'h0100, 0, 0, 16'h00AA, 3'b001, 16'hFFAA, 3'b100};
    tbl[6]  = '{LOAD_W, 16'h0102, 0, 0, 16'h0000, 3'b010, 16'h0000, 3'b010};
    tbl[7]  = '{STORE_B, 16'h0050, 16'h1285, 0, 0, 0, 0, 0};
    tbl[8]  = '{LOAD_B, 16'h0050, 0, 1, 16'h0085, 3'b001, 16'hFF85, 3'b100};
    tbl[9]  = '{LOAD_B, 16'h0051, 0, 0, 16'h0000, 3'b010, 16'h0000, 3'b010};
    tbl[10] = '{STORE_W, 16'h0060, 16'h1234, 0, 0, 0, 0, 0};
    tbl[11] = '{LOAD_B, 16'h0061, 0, 1, 16'h0012, 3'b001, 16'h0012, 3'b001};
    tbl[12] = '{LOAD_W, 16'h0060, 0, 1, 16'h1234, 3'b001, 16'h1234, 3'b001};
    tbl[13] = '{STORE_W, 16'h0070, 16'h8000, 0, 0, 0, 0, 0};
    tbl[14] = '{LOAD_W, 16'h0070, 0, 1, 16'h8000, 3'b100, 16'h8000, 3'b100};
    tbl[15] = '{LOAD_W, 16'h0040, 0, 0, 16'h7FEF, 3'b001, 16'h7FEF, 3'b001};

    rst_n = 1'b0; req_valid = 1'b0; drain_all = 1'b0;
    req_op = LOAD_W; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_resp_valid", {31'b0, resp_valid0}, 0);
    chk("rst_resp_rdata", resp_rdata0, 0);
    chk("rst_resp_cc", resp_cc0, 0);
    chk("rst_sb_empty", {31'b0, sb_empty0}, 1);
    chk("rst_d_read", {31'b0, d_read0}, 0);
    chk("rst_d_write", {31'b0, d_write0}, 0);
    chk("rst_d_address", d_address0, 0);
    chk("rst_d_be", d_byte_enable0, 0);

    for (int i = 0; i < 16; i++) begin
      issue(tbl[i], w, ra);
      if (i == 3) chk("partial_stall", w > 0, 1);
    end
    wait_empty("table_drained");

    lat = 3;
    wlog.delete();
    for (int i = 0; i < 8; i++) begin
      v = '{STORE_W, 16'h0020 + 16'(2 * i), 16'hA000 + 16'(i),
            0, 0, 0, 0, 0};
      issue(v, w, ra);
      if (i == 4) begin
        chk("full_stall", w > 0, 1);
        chk("push_on_pop", {31'b0, ra}, 1);
      end
    end
    wait_empty("wrap_drained");
    chk("wrap_count", wlog.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < wlog.size()) begin
        chk("wrap_addr", wlog[i].a, 16'h0020 + 16'(2 * i));
        chk("wrap_data", wlog[i].d, 16'hA000 + 16'(i));
      end

    lat = 2;
    wlog.delete();
    for (int i = 0; i < 3; i++) begin
      v = '{STORE_W, 16'h0090 + 16'(2 * i), 16'h5000 + 16'(i),
            0, 0, 0, 0, 0};
      issue(v, w, ra);
    end
    drain_all = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = STORE_W;
    req_addr = 16'h00A0; req_wdata = 16'h9999;
    #1;
    chk("drain_all_ready", {31'b0, req_ready0}, 0);
    chk("drain_all_busy", {31'b0, sb_empty0}, 0);
    n = 0;
    while (!sb_empty0 && n < 200) begin @(negedge clk); #1; n++; end
    req_valid = 1'b0;
    chk("drain_all_empty", {31'b0, sb_empty0}, 1);
    chk("drain_all_writes", wlog.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < wlog.size())
        chk("drain_all_order", wlog[i].a, 16'h0090 + 16'(2 * i));
    drain_all = 1'b0;

    lat = 20;
    wait_empty("pre_reset_empty");
    v = '{STORE_W, 16'h00C0, 16'h4444, 0, 0, 0, 0, 0};
    issue(v, w, ra);
    n = 0;
    while (!d_write0 && n < 50) begin @(negedge clk); n++; end
    chk("t5_dwrite_up", {31'b0, d_write0}, 1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("t5_dwrite_drop", {31'b0, d_write0}, 0);
    chk("t5_dread_low", {31'b0, d_read0}, 0);
    chk("t5_sb_empty", {31'b0, sb_empty0}, 1);
    chk("t5_resp_valid", {31'b0, resp_valid0}, 0);
    rst_n = 1'b1;
    lat = 1;
    v = '{LOAD_W, 16'h00C0, 0, 0, 16'h0000, 3'b010, 16'h0000, 3'b010};
    issue(v, w, ra);

    n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
